// File: rtl/vga_pixel_fetch_pkg.sv
// Shared types and frame constants for the cellular-RAM background pixel fetcher.
package vga_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      WAIT    = 2'd2,
      CAPTURE = 2'd3
   } fetch_state_e;

   localparam int H_PIX          = 640;
   localparam int V_PIX          = 480;
   localparam int BYTES_PER_WORD = 2;
   localparam int WORD_W         = 16;

   // Low byte is the earlier pixel in the stored image.
   function automatic logic [7:0] pixel_byte(input logic [WORD_W-1:0] word, input logic sel);
      return sel ? word[15:8] : word[7:0];
   endfunction

endpackage

// File: rtl/vga_pixel_fetch_if.sv
// RAM pin bundle plus the pixel handshake towards the VGA colour stage.
interface vga_pixel_fetch_if #(
   parameter int ADDR_W = 26
);
   logic              frame_start;
   logic              pix_rd;
   logic [15:0]       MemDB;
   logic [ADDR_W-1:0] MemAdr;
   logic              ce_L;
   logic              oe_L;
   logic              we_L;
   logic              lb_L;
   logic              ub_L;
   logic              RamADV_L;
   logic              RamCLK;
   logic              RamCRE;
   logic              FlashCS;
   logic [7:0]        pix_data;
   logic              pix_valid;
   logic              underrun;

   modport master (
      input  frame_start, pix_rd, MemDB,
      output MemAdr, ce_L, oe_L, we_L, lb_L, ub_L, RamADV_L, RamCLK, RamCRE, FlashCS,
      output pix_data, pix_valid, underrun
   );

   modport slave (
      output frame_start, pix_rd, MemDB,
      input  MemAdr, ce_L, oe_L, we_L, lb_L, ub_L, RamADV_L, RamCLK, RamCRE, FlashCS,
      input  pix_data, pix_valid, underrun
   );
endinterface

// File: rtl/vga_pixel_fetch_word_fifo.sv
// Small word FIFO between the RAM capture and the pixel output stage; flush wins over push/pop.
module word_fifo
   import vga_fetch_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [WORD_W-1:0]      data_i,
   input  logic                   pop_i,
   output logic [WORD_W-1:0]      data_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W:0]    count_q;
   logic              do_push_s;
   logic              do_pop_s;

   assign do_push_s = push_i && !flush_i && (count_q != (PTR_W+1)'(DEPTH));
   assign do_pop_s  = pop_i && !flush_i && (count_q != (PTR_W+1)'(0));
   assign data_o    = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= PTR_W'(0);
         rd_ptr_q <= PTR_W'(0);
         count_q  <= (PTR_W+1)'(0);
      end else if (flush_i) begin
         wr_ptr_q <= PTR_W'(0);
         rd_ptr_q <= PTR_W'(0);
         count_q  <= (PTR_W+1)'(0);
      end else begin
         if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + {{PTR_W{1'b0}}, do_push_s} - {{PTR_W{1'b0}}, do_pop_s};
      end
   end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Async-mode cellular-RAM read engine streaming background pixels, one byte per pix_rd.
module vga_pixel_fetch
   import vga_fetch_pkg::*;
#(
   parameter int                ADDR_W      = 26,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = {ADDR_W{1'b0}},
   parameter int                FRAME_WORDS = H_PIX * V_PIX / BYTES_PER_WORD,
   parameter int                WAIT_CYCLES = 4,
   parameter int                FIFO_DEPTH  = 8
) (
   input logic               clk,
   input logic               rst,
   vga_pixel_fetch_if.master bus
);
   localparam int CNT_W = $clog2(FRAME_WORDS + 1);
   localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int WC_W  = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES - 1) : 1;

   fetch_state_e      state_q;
   logic [WC_W-1:0]   wait_cnt_q;
   logic [CNT_W-1:0]  word_cnt_q;
   logic              active_q;
   logic [ADDR_W-1:0] adr_q;
   logic              ce_n_q;
   logic              oe_n_q;
   logic [7:0]        pix_data_q, pix_data_d;
   logic              pix_valid_q, pix_valid_d;
   logic              byte_sel_q, byte_sel_d;
   logic              underrun_q, underrun_d;

   logic [WORD_W-1:0] head_s;
   logic [FC_W-1:0]   fifo_cnt_s;
   logic [FC_W:0]     occupancy_s;
   logic              inflight_s, issue_s, last_wait_s, push_s, take_s, load_s, pop_s;

   // A read in SETUP/WAIT already owns a FIFO slot, so it counts towards occupancy.
   assign inflight_s  = (state_q == SETUP) || (state_q == WAIT);
   assign occupancy_s = {1'b0, fifo_cnt_s} + {{FC_W{1'b0}}, inflight_s};
   assign issue_s     = active_q && (occupancy_s < (FC_W+1)'(FIFO_DEPTH))
                        && (word_cnt_q < CNT_W'(FRAME_WORDS));
   assign last_wait_s = (state_q == WAIT) && (wait_cnt_q == WC_W'(WAIT_CYCLES - 2));
   assign push_s      = last_wait_s && !bus.frame_start;
   assign take_s      = bus.pix_rd && pix_valid_q && !bus.frame_start;
   assign load_s      = (!pix_valid_q || take_s) && (fifo_cnt_s != FC_W'(0)) && !bus.frame_start;
   assign pop_s       = load_s && byte_sel_q;

   word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (bus.frame_start),
      .push_i  (push_s),
      .data_i  (bus.MemDB),
      .pop_i   (pop_s),
      .data_o  (head_s),
      .count_o (fifo_cnt_s)
   );

   // Read sequencer: RAM strobes and address are registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         wait_cnt_q <= WC_W'(0);
         word_cnt_q <= CNT_W'(0);
         active_q   <= 1'b0;
         adr_q      <= BASE_ADDR;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
      end else if (bus.frame_start) begin
         state_q    <= IDLE;
         wait_cnt_q <= WC_W'(0);
         word_cnt_q <= CNT_W'(0);
         active_q   <= 1'b1;
         adr_q      <= BASE_ADDR;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (issue_s) begin
                  state_q <= SETUP;
                  ce_n_q  <= 1'b0;
                  oe_n_q  <= 1'b0;
               end
            end
            SETUP: begin
               state_q    <= WAIT;
               wait_cnt_q <= WC_W'(0);
            end
            WAIT: begin
               if (last_wait_s) begin
                  state_q    <= CAPTURE;
                  ce_n_q     <= 1'b1;
                  oe_n_q     <= 1'b1;
                  adr_q      <= adr_q + ADDR_W'(1);
                  word_cnt_q <= word_cnt_q + CNT_W'(1);
               end else begin
                  wait_cnt_q <= wait_cnt_q + WC_W'(1);
               end
            end
            CAPTURE: state_q <= IDLE;
            default: begin
               state_q <= IDLE;
               ce_n_q  <= 1'b1;
               oe_n_q  <= 1'b1;
            end
         endcase
      end
   end

   // Output byte stage refills from the FIFO head whenever it is empty or being taken.
   always_comb begin
      pix_data_d  = pix_data_q;
      pix_valid_d = pix_valid_q;
      byte_sel_d  = byte_sel_q;
      underrun_d  = underrun_q;
      if (bus.frame_start) begin
         pix_data_d  = 8'h00;
         pix_valid_d = 1'b0;
         byte_sel_d  = 1'b0;
         underrun_d  = 1'b0;
      end else begin
         if (load_s) begin
            pix_data_d  = pixel_byte(head_s, byte_sel_q);
            pix_valid_d = 1'b1;
            byte_sel_d  = ~byte_sel_q;
         end else if (take_s) begin
            pix_data_d  = 8'h00;
            pix_valid_d = 1'b0;
         end else begin
            pix_data_d  = pix_data_q;
            pix_valid_d = pix_valid_q;
         end
         if (bus.pix_rd && !pix_valid_q) begin
            underrun_d = 1'b1;
         end else begin
            underrun_d = underrun_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_data_q  <= 8'h00;
         pix_valid_q <= 1'b0;
         byte_sel_q  <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         pix_data_q  <= pix_data_d;
         pix_valid_q <= pix_valid_d;
         byte_sel_q  <= byte_sel_d;
         underrun_q  <= underrun_d;
      end
   end

   assign bus.MemAdr    = adr_q;
   assign bus.ce_L      = ce_n_q;
   assign bus.oe_L      = oe_n_q;
   assign bus.lb_L      = ce_n_q;
   assign bus.ub_L      = ce_n_q;
   assign bus.we_L      = 1'b1;
   assign bus.RamADV_L  = 1'b0;
   assign bus.RamCLK    = 1'b0;
   assign bus.RamCRE    = 1'b0;
   assign bus.FlashCS   = 1'b1;
   assign bus.pix_data  = pix_data_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench: RAM model returns the word address, pixel stream checked against hand-derived bytes.
module tb_vga_pixel_fetch;
   logic clk;
   logic rst;

   vga_pixel_fetch_if ifc  ();
   vga_pixel_fetch_if ifc4 ();

   assign ifc.MemDB  = ifc.MemAdr[15:0];
   assign ifc4.MemDB = ifc4.MemAdr[15:0];

   vga_pixel_fetch u_dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   vga_pixel_fetch #(.FRAME_WORDS(4)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (ifc4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         first_valid, first_low, first_run, ce_run, nb, reads, max_adr;
   logic       prev_ce;
   logic [7:0] got [16];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic watch_main(input int ncyc, output int n_reads);
      logic p;
      p = 1'b1;
      n_reads = 0;
      for (int c = 0; c < ncyc; c++) begin
         if (p && !ifc.ce_L) n_reads++;
         p = ifc.ce_L;
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      ifc.frame_start  = 1'b0;
      ifc.pix_rd       = 1'b0;
      ifc4.frame_start = 1'b0;
      ifc4.pix_rd      = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // reset state, and no reads before the first frame_start
      check_eq("rst_ce_L", ifc.ce_L, 1'b1);
      check_eq("rst_oe_L", ifc.oe_L, 1'b1);
      check_eq("rst_lb_ub", {ifc.lb_L, ifc.ub_L}, 2'b11);
      check_eq("rst_MemAdr", ifc.MemAdr, 26'h0);
      check_eq("rst_pix_valid", ifc.pix_valid, 1'b0);
      check_eq("rst_pix_data", ifc.pix_data, 8'h00);
      check_eq("rst_underrun", ifc.underrun, 1'b0);
      check_eq("const_pins", {ifc.we_L, ifc.RamADV_L, ifc.RamCLK, ifc.RamCRE, ifc.FlashCS}, 5'b10001);
      watch_main(12, reads);
      check_eq("idle_no_reads", reads, 0);

      // continuous pix_rd from frame_start: latency, strobe width, byte order
      ifc.frame_start = 1'b1;
      ifc.pix_rd      = 1'b1;
      first_valid = -1; first_low = -1; first_run = -1; ce_run = 0; nb = 0;
      for (int c = 0; c < 150 && nb < 6; c++) begin
         if (c > 0 && ifc.pix_valid && first_valid < 0) first_valid = c;
         if (c > 0 && ifc.pix_valid && ifc.pix_rd) begin
            got[nb] = ifc.pix_data;
            nb++;
         end
         if (!ifc.ce_L) begin
            if (first_low < 0) first_low = c;
            ce_run++;
         end else if (ce_run > 0 && first_run < 0) begin
            first_run = ce_run;
         end
         tick();
         ifc.frame_start = 1'b0;
      end
      ifc.pix_rd = 1'b0;
      check_eq("first_setup_cycle", first_low, 2);
      check_eq("ce_low_width", first_run, 4);
      check_eq("first_valid_cycle", first_valid, 7);
      check_eq("stream_nbytes", nb, 6);
      check_eq("stream_b0", got[0], 8'h00);
      check_eq("stream_b1", got[1], 8'h00);
      check_eq("stream_b2", got[2], 8'h01);
      check_eq("stream_b3", got[3], 8'h00);
      check_eq("stream_b4", got[4], 8'h02);
      check_eq("stream_b5", got[5], 8'h00);
      check_eq("stream_underrun", ifc.underrun, 1'b1);

      // no consumer: FIFO fills with exactly FIFO_DEPTH words
      ifc.frame_start = 1'b1;
      tick();
      ifc.frame_start = 1'b0;
      watch_main(99, reads);
      check_eq("fill_reads", reads, 8);
      check_eq("fill_ce_idle", ifc.ce_L, 1'b1);
      check_eq("fill_valid", ifc.pix_valid, 1'b1);
      check_eq("fill_data", ifc.pix_data, 8'h00);
      check_eq("fill_underrun", ifc.underrun, 1'b0);
      ifc.pix_rd = 1'b1;
      tick();
      tick();
      ifc.pix_rd = 1'b0;
      check_eq("pair_next_byte", ifc.pix_data, 8'h01);
      watch_main(60, reads);
      check_eq("pair_one_read", reads, 1);

      // abort during WAIT with four words buffered
      ifc.frame_start = 1'b1;
      tick();
      ifc.frame_start = 1'b0;
      ifc.pix_rd      = 1'b1;
      tick();
      ifc.pix_rd = 1'b0;
      repeat (26) tick();
      check_eq("abort_pre_ce", ifc.ce_L, 1'b0);
      check_eq("abort_pre_adr", ifc.MemAdr, 26'h4);
      check_eq("abort_pre_underrun", ifc.underrun, 1'b1);
      ifc.frame_start = 1'b1;
      tick();
      ifc.frame_start = 1'b0;
      check_eq("abort_ce_oe", {ifc.ce_L, ifc.oe_L}, 2'b11);
      check_eq("abort_valid", ifc.pix_valid, 1'b0);
      check_eq("abort_adr", ifc.MemAdr, 26'h0);
      check_eq("abort_underrun", ifc.underrun, 1'b0);
      tick();
      check_eq("restart_ce", ifc.ce_L, 1'b0);
      check_eq("restart_adr", ifc.MemAdr, 26'h0);
      repeat (4) tick();
      check_eq("restart_valid_c6", ifc.pix_valid, 1'b0);
      tick();
      check_eq("restart_valid_c7", ifc.pix_valid, 1'b1);
      check_eq("restart_data", ifc.pix_data, 8'h00);

      // frame_start together with pix_rd: pix_rd is ignored
      ifc.pix_rd = 1'b1;
      repeat (20) tick();
      check_eq("pre_fs_underrun", ifc.underrun, 1'b1);
      ifc.frame_start = 1'b1;
      tick();
      ifc.frame_start = 1'b0;
      ifc.pix_rd      = 1'b0;
      check_eq("fs_rd_underrun", ifc.underrun, 1'b0);
      check_eq("fs_rd_valid", ifc.pix_valid, 1'b0);
      repeat (30) tick();
      check_eq("fs_rd_first", {ifc.pix_valid, ifc.pix_data}, 9'h100);
      ifc.pix_rd = 1'b1;
      tick();
      check_eq("fs_rd_b1", ifc.pix_data, 8'h00);
      tick();
      check_eq("fs_rd_b2", ifc.pix_data, 8'h01);
      tick();
      check_eq("fs_rd_b3", ifc.pix_data, 8'h00);
      ifc.pix_rd = 1'b0;

      // short frame of four words with a continuous consumer
      ifc4.frame_start = 1'b1;
      ifc4.pix_rd      = 1'b1;
      tick();
      ifc4.frame_start = 1'b0;
      reads = 0; max_adr = 0; nb = 0; prev_ce = 1'b1;
      for (int c = 1; c < 80; c++) begin
         if (!ifc4.ce_L) begin
            if (prev_ce) reads++;
            if (int'(ifc4.MemAdr) > max_adr) max_adr = int'(ifc4.MemAdr);
         end
         if (ifc4.pix_valid && ifc4.pix_rd && nb < 16) begin
            got[nb] = ifc4.pix_data;
            nb++;
         end
         prev_ce = ifc4.ce_L;
         tick();
      end
      check_eq("short_reads", reads, 4);
      check_eq("short_max_adr", max_adr, 3);
      check_eq("short_nbytes", nb, 8);
      check_eq("short_b6", got[6], 8'h03);
      check_eq("short_b7", got[7], 8'h00);
      check_eq("short_end_valid", ifc4.pix_valid, 1'b0);
      check_eq("short_underrun", ifc4.underrun, 1'b1);
      check_eq("short_ce_idle", ifc4.ce_L, 1'b1);
      ifc4.pix_rd = 1'b0;

      // asynchronous reset in the middle of a read
      ifc.frame_start = 1'b1;
      tick();
      ifc.frame_start = 1'b0;
      repeat (8) tick();
      check_eq("midrd_pre_ce", ifc.ce_L, 1'b0);
      check_eq("midrd_pre_adr", ifc.MemAdr, 26'h1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("midrd_ctrl", {ifc.ce_L, ifc.oe_L, ifc.lb_L, ifc.ub_L}, 4'hF);
      check_eq("midrd_valid", ifc.pix_valid, 1'b0);
      check_eq("midrd_adr", ifc.MemAdr, 26'h0);
      tick();
      rst = 1'b0;
      watch_main(20, reads);
      check_eq("post_rst_no_reads", reads, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
